can_bsp_mon: RTL and testbench

- Second-generation CAN bit stream processor, replacing can_bsp, between the bit-timing block (sample_point/tx_point strobes) and the frame-level MAC.
- Does TX bit stuffing and RX destuffing with a parametrised run length.
- Adds what can_bsp lacks: stuff-error detection, bit monitoring (bit error / arbitration loss / ACK-slot exemption), a TX consume handshake, RX valid strobe and an optional input synchroniser.

---
 rtl/can_bsp_mon.sv | 169 ++++++++++++++++
 tb/tb_can_bsp_mon.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bsp_mon.sv
// CAN bit stream processor: TX stuffing, RX destuffing with stuff-error detection,
// and bus monitoring (bit error / arbitration loss) against the synchronised RX level.
module can_bsp_mon #(
  parameter int STUFF_LEN   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic tx_point,
  input  logic rx_in,
  input  logic tx_data_in,
  input  logic enable_tx_stuffing,
  input  logic enable_rx_stuffing,
  input  logic monitor_en,
  input  logic arb_field,
  input  logic ack_slot,
  input  logic err_clear,
  output logic tx_out,
  output logic tx_stall,
  output logic tx_ack,
  output logic rx_data_out,
  output logic rx_valid,
  output logic rx_stall,
  output logic stuff_err,
  output logic bit_err,
  output logic arb_lost
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic rx_s;
  genvar gi;

  // Synchroniser chain presets to recessive so reset never looks like a SOF edge.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = rx_in;
    end else begin : g_sync
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        logic d_in;
        logic q;
        if (gi == 0) begin : g_first
          assign d_in = rx_in;
        end else begin : g_rest
          assign d_in = g_stage[gi-1].q;
        end
        always_ff @(posedge clk) begin
          if (rst) q <= 1'b1;
          else     q <= d_in;
        end
      end
      assign rx_s = g_stage[SYNC_STAGES-1].q;
    end
  endgenerate

  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic             tx_last_reg, tx_last_next;
  logic             tx_stuff_reg, tx_stuff_next;
  logic             tx_out_next, tx_ack_next, d_eff;

  always_comb begin
    d_eff         = arb_lost | tx_data_in;
    tx_out_next   = tx_out;
    tx_cnt_next   = tx_cnt_reg;
    tx_last_next  = tx_last_reg;
    tx_stuff_next = tx_stuff_reg;
    tx_ack_next   = 1'b0;
    if (tx_point) begin
      if (!enable_tx_stuffing) begin
        tx_out_next   = d_eff;
        tx_cnt_next   = '0;
        tx_last_next  = d_eff;
        tx_stuff_next = 1'b0;
        tx_ack_next   = 1'b1;
      end else if (tx_cnt_reg == RUN_MAX) begin
        tx_out_next   = ~tx_last_reg;
        tx_last_next  = ~tx_last_reg;
        tx_cnt_next   = ONE;
        tx_stuff_next = 1'b1;
      end else begin
        tx_out_next   = d_eff;
        tx_last_next  = d_eff;
        tx_stuff_next = 1'b0;
        tx_ack_next   = 1'b1;
        tx_cnt_next   = (tx_cnt_reg != '0 && d_eff == tx_last_reg) ? tx_cnt_reg + ONE : ONE;
      end
    end
  end

  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic             rx_last_reg, rx_last_next;
  logic             rx_data_next, rx_valid_next, rx_stall_next, stuff_set;

  always_comb begin
    rx_data_next  = rx_data_out;
    rx_cnt_next   = rx_cnt_reg;
    rx_last_next  = rx_last_reg;
    rx_valid_next = 1'b0;
    rx_stall_next = 1'b0;
    stuff_set     = 1'b0;
    if (sample_point) begin
      if (!enable_rx_stuffing) begin
        rx_data_next  = rx_s;
        rx_valid_next = ~stuff_err;
        rx_cnt_next   = '0;
        rx_last_next  = rx_s;
      end else if (rx_cnt_reg == RUN_MAX) begin
        if (rx_s != rx_last_reg) begin
          rx_stall_next = 1'b1;
          rx_last_next  = rx_s;
          rx_cnt_next   = ONE;
        end else begin
          stuff_set   = 1'b1;
          rx_cnt_next = '0;
        end
      end else begin
        rx_data_next  = rx_s;
        rx_valid_next = ~stuff_err;
        rx_last_next  = rx_s;
        rx_cnt_next   = (rx_cnt_reg != '0 && rx_s == rx_last_reg) ? rx_cnt_reg + ONE : ONE;
      end
    end
  end

  // A dominant bus under our recessive bit only loses arbitration for real data bits.
  logic mon_mismatch, recessive_lost, arb_set, bit_set;
  assign mon_mismatch   = sample_point & monitor_en & (rx_s != tx_out);
  assign recessive_lost = tx_out & ~rx_s;
  assign arb_set = mon_mismatch & recessive_lost & ~ack_slot & arb_field & ~tx_stuff_reg;
  assign bit_set = mon_mismatch & ~(recessive_lost & ack_slot) & ~arb_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out       <= 1'b1;
      tx_stall     <= 1'b0;
      tx_ack       <= 1'b0;
      tx_cnt_reg   <= '0;
      tx_last_reg  <= 1'b1;
      tx_stuff_reg <= 1'b0;
      rx_data_out  <= 1'b1;
      rx_valid     <= 1'b0;
      rx_stall     <= 1'b0;
      rx_cnt_reg   <= '0;
      rx_last_reg  <= 1'b1;
      stuff_err    <= 1'b0;
      bit_err      <= 1'b0;
      arb_lost     <= 1'b0;
    end else begin
      tx_out       <= tx_out_next;
      tx_stall     <= enable_tx_stuffing && (tx_cnt_next == RUN_MAX);
      tx_ack       <= tx_ack_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_last_reg  <= tx_last_next;
      tx_stuff_reg <= tx_stuff_next;
      rx_data_out  <= rx_data_next;
      rx_valid     <= rx_valid_next;
      rx_stall     <= rx_stall_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_last_reg  <= rx_last_next;
      stuff_err    <= stuff_set | (stuff_err & ~err_clear);
      bit_err      <= bit_set   | (bit_err   & ~err_clear);
      arb_lost     <= arb_set   | (arb_lost  & ~err_clear);
    end
  end

endmodule

// File: tb/tb_can_bsp_mon.sv
// Directed bench for can_bsp_mon: default build plus a STUFF_LEN=3 / no-sync build on shared stimulus.
module tb_can_bsp_mon;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sample_point, tx_point, rx_in, tx_data_in;
  logic enable_tx_stuffing, enable_rx_stuffing, monitor_en, arb_field, ack_slot, err_clear;
  logic tx_out, tx_stall, tx_ack, rx_data_out, rx_valid, rx_stall, stuff_err, bit_err, arb_lost;
  logic tx_out_3, tx_stall_3, tx_ack_3, rx_data_out_3, rx_valid_3, rx_stall_3;
  logic stuff_err_3, bit_err_3, arb_lost_3;

  int checks = 0;
  int errors = 0;

  can_bsp_mon dut (
    .clk(clk), .rst(rst), .sample_point(sample_point), .tx_point(tx_point), .rx_in(rx_in),
    .tx_data_in(tx_data_in), .enable_tx_stuffing(enable_tx_stuffing),
    .enable_rx_stuffing(enable_rx_stuffing), .monitor_en(monitor_en), .arb_field(arb_field),
    .ack_slot(ack_slot), .err_clear(err_clear), .tx_out(tx_out), .tx_stall(tx_stall),
    .tx_ack(tx_ack), .rx_data_out(rx_data_out), .rx_valid(rx_valid), .rx_stall(rx_stall),
    .stuff_err(stuff_err), .bit_err(bit_err), .arb_lost(arb_lost)
  );

  can_bsp_mon #(.STUFF_LEN(3), .SYNC_STAGES(0)) dut3 (
    .clk(clk), .rst(rst), .sample_point(sample_point), .tx_point(tx_point), .rx_in(rx_in),
    .tx_data_in(tx_data_in), .enable_tx_stuffing(enable_tx_stuffing),
    .enable_rx_stuffing(enable_rx_stuffing), .monitor_en(monitor_en), .arb_field(arb_field),
    .ack_slot(ack_slot), .err_clear(err_clear), .tx_out(tx_out_3), .tx_stall(tx_stall_3),
    .tx_ack(tx_ack_3), .rx_data_out(rx_data_out_3), .rx_valid(rx_valid_3), .rx_stall(rx_stall_3),
    .stuff_err(stuff_err_3), .bit_err(bit_err_3), .arb_lost(arb_lost_3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_point = 1'b0; sample_point = 1'b0; err_clear = 1'b0;
    rx_in = 1'b1; tx_data_in = 1'b1; enable_tx_stuffing = 1'b0; enable_rx_stuffing = 1'b0;
    monitor_en = 1'b0; arb_field = 1'b0; ack_slot = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic tx_pulse();
    tx_point = 1'b1;
    tick();
    tx_point = 1'b0;
  endtask

  // Hold the bus level long enough to pass the two-stage synchroniser, then sample it.
  task automatic rx_bit(input logic b, input logic clr);
    rx_in = b;
    tick(); tick();
    sample_point = 1'b1; err_clear = clr;
    tick();
    sample_point = 1'b0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    do_reset();
    rst = 1'b1; tx_point = 1'b1; sample_point = 1'b1; rx_in = 1'b0; tx_data_in = 1'b0;
    tick(); tick();
    got = {tx_out, tx_stall, tx_ack, rx_data_out, rx_valid, rx_stall, stuff_err, bit_err, arb_lost};
    checks++;
    if (got !== 9'b100100000) begin
      errors++; $display("FAIL reset_state got %b exp %b", got, 9'b100100000);
    end
    got = {tx_out_3, tx_stall_3, tx_ack_3, rx_data_out_3, rx_valid_3, rx_stall_3,
           stuff_err_3, bit_err_3, arb_lost_3};
    checks++;
    if (got !== 9'b100100000) begin
      errors++; $display("FAIL reset_state_3 got %b exp %b", got, 9'b100100000);
    end
    tx_point = 1'b0; sample_point = 1'b0; rx_in = 1'b1; rst = 1'b0;
    tick();
    checks++;
    if (tx_ack !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL strobe_in_reset got ack %b valid %b exp 0 0", tx_ack, rx_valid);
    end
  endtask

  task automatic test_tx_stuff();
    logic [7:0] exp_out, exp_ack, exp_stall;
    int acks;
    exp_out = 8'b0010_0000; exp_ack = 8'b1101_1111; exp_stall = 8'b0010_0000;
    acks = 0;
    do_reset();
    enable_tx_stuffing = 1'b1; tx_data_in = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_stall !== exp_stall[i]) begin
        errors++; $display("FAIL tx_stall[%0d] got %b exp %b", i, tx_stall, exp_stall[i]);
      end
      tx_pulse();
      checks++;
      if (tx_out !== exp_out[i]) begin
        errors++; $display("FAIL tx_out[%0d] got %b exp %b", i, tx_out, exp_out[i]);
      end
      checks++;
      if (tx_ack !== exp_ack[i]) begin
        errors++; $display("FAIL tx_ack[%0d] got %b exp %b", i, tx_ack, exp_ack[i]);
      end
      if (tx_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 7) begin
      errors++; $display("FAIL tx_ack_count got %0d exp 7", acks);
    end
    tick();
    checks++;
    if (tx_ack !== 1'b0) begin
      errors++; $display("FAIL tx_ack_pulse got %b exp 0", tx_ack);
    end
  endtask

  task automatic test_rx_destuff();
    logic [7:0] bus, exp_valid, exp_stall, exp_data;
    int valids;
    bus = 8'b1011_1110; exp_valid = 8'b1011_1111; exp_stall = 8'b0100_0000; exp_data = 8'b1011_1110;
    valids = 0;
    do_reset();
    enable_rx_stuffing = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_bit(bus[i], 1'b0);
      checks++;
      if (rx_valid !== exp_valid[i] || rx_stall !== exp_stall[i]) begin
        errors++;
        $display("FAIL rx_strobes[%0d] got valid %b stall %b exp %b %b",
                 i, rx_valid, rx_stall, exp_valid[i], exp_stall[i]);
      end
      if (exp_valid[i]) begin
        checks++;
        if (rx_data_out !== exp_data[i]) begin
          errors++; $display("FAIL rx_data[%0d] got %b exp %b", i, rx_data_out, exp_data[i]);
        end
      end
      if (rx_valid === 1'b1) valids++;
    end
    checks++;
    if (valids !== 7) begin
      errors++; $display("FAIL rx_valid_count got %0d exp 7", valids);
    end
  endtask

  task automatic test_stuff_err();
    do_reset();
    enable_rx_stuffing = 1'b1;
    rx_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) rx_bit(1'b1, 1'b0);
    checks++;
    if (stuff_err !== 1'b0 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL pre_stuff_err got err %b valid %b exp 0 1", stuff_err, rx_valid);
    end
    rx_bit(1'b1, 1'b0);
    checks++;
    if (stuff_err !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL stuff_err_set got err %b valid %b exp 1 0", stuff_err, rx_valid);
    end
    rx_bit(1'b0, 1'b0);
    checks++;
    if (rx_valid !== 1'b0 || rx_data_out !== 1'b0) begin
      errors++; $display("FAIL valid_suppressed got valid %b data %b exp 0 0", rx_valid, rx_data_out);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (stuff_err !== 1'b0) begin
      errors++; $display("FAIL stuff_err_clear got %b exp 0", stuff_err);
    end
    for (int i = 0; i < 4; i++) rx_bit(1'b0, 1'b0);
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++; $display("FAIL valid_after_clear got %b exp 1", rx_valid);
    end
    rx_bit(1'b0, 1'b1);
    checks++;
    if (stuff_err !== 1'b1) begin
      errors++; $display("FAIL set_beats_clear got %b exp 1", stuff_err);
    end
  endtask

  task automatic test_monitor();
    do_reset();
    tx_data_in = 1'b1;
    tx_pulse();
    monitor_en = 1'b1; arb_field = 1'b1;
    rx_bit(1'b0, 1'b0);
    checks++;
    if (arb_lost !== 1'b1 || bit_err !== 1'b0) begin
      errors++; $display("FAIL arb_lost got arb %b bit %b exp 1 0", arb_lost, bit_err);
    end
    tx_data_in = 1'b0;
    tx_pulse();
    checks++;
    if (tx_out !== 1'b1) begin
      errors++; $display("FAIL arb_lost_recessive got %b exp 1", tx_out);
    end

    do_reset();
    tx_data_in = 1'b1;
    tx_pulse();
    monitor_en = 1'b1;
    rx_bit(1'b0, 1'b0);
    checks++;
    if (bit_err !== 1'b1 || arb_lost !== 1'b0) begin
      errors++; $display("FAIL bit_err got bit %b arb %b exp 1 0", bit_err, arb_lost);
    end

    do_reset();
    tx_data_in = 1'b1;
    tx_pulse();
    monitor_en = 1'b1; ack_slot = 1'b1;
    rx_bit(1'b0, 1'b0);
    checks++;
    if (bit_err !== 1'b0 || arb_lost !== 1'b0) begin
      errors++; $display("FAIL ack_exempt got bit %b arb %b exp 0 0", bit_err, arb_lost);
    end

    // Stuff bit (recessive) overwritten in the arbitration field is a bit error.
    do_reset();
    enable_tx_stuffing = 1'b1; tx_data_in = 1'b0;
    repeat (6) tx_pulse();
    checks++;
    if (tx_out !== 1'b1) begin
      errors++; $display("FAIL stuff_bit_out got %b exp 1", tx_out);
    end
    monitor_en = 1'b1; arb_field = 1'b1;
    rx_bit(1'b0, 1'b0);
    checks++;
    if (bit_err !== 1'b1 || arb_lost !== 1'b0) begin
      errors++; $display("FAIL stuff_bit_mon got bit %b arb %b exp 1 0", bit_err, arb_lost);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (bit_err !== 1'b0) begin
      errors++; $display("FAIL bit_err_clear got %b exp 0", bit_err);
    end
  endtask

  task automatic test_short_param();
    logic [3:0] exp_out, exp_ack, exp_stall;
    exp_out = 4'b1000; exp_ack = 4'b0111; exp_stall = 4'b1000;
    do_reset();
    enable_tx_stuffing = 1'b1; tx_data_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_stall_3 !== exp_stall[i]) begin
        errors++; $display("FAIL tx_stall_3[%0d] got %b exp %b", i, tx_stall_3, exp_stall[i]);
      end
      tx_pulse();
      checks++;
      if (tx_out_3 !== exp_out[i] || tx_ack_3 !== exp_ack[i]) begin
        errors++;
        $display("FAIL tx_3[%0d] got out %b ack %b exp %b %b",
                 i, tx_out_3, tx_ack_3, exp_out[i], exp_ack[i]);
      end
    end
    enable_tx_stuffing = 1'b0;
    rx_in = 1'b0; sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    checks++;
    if (rx_valid_3 !== 1'b1 || rx_data_out_3 !== 1'b0) begin
      errors++; $display("FAIL rx_nosync got valid %b data %b exp 1 0", rx_valid_3, rx_data_out_3);
    end
    checks++;
    if (rx_data_out !== 1'b1) begin
      errors++; $display("FAIL rx_sync_delay got %b exp 1", rx_data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_stall;
    exp_stall = 5'b10000;
    do_reset();
    enable_tx_stuffing = 1'b1; tx_data_in = 1'b0;
    repeat (4) tx_pulse();
    rst = 1'b1; tx_point = 1'b1;
    tick();
    rst = 1'b0; tx_point = 1'b0;
    checks++;
    if (tx_out !== 1'b1 || tx_stall !== 1'b0 || tx_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got out %b stall %b ack %b exp 1 0 0", tx_out, tx_stall, tx_ack);
    end
    for (int i = 0; i < 5; i++) begin
      tx_pulse();
      checks++;
      if (tx_stall !== exp_stall[i] || tx_out !== 1'b0) begin
        errors++;
        $display("FAIL fresh_run[%0d] got stall %b out %b exp %b 0", i, tx_stall, tx_out, exp_stall[i]);
      end
    end
    tx_pulse();
    checks++;
    if (tx_out !== 1'b1 || tx_ack !== 1'b0) begin
      errors++; $display("FAIL fresh_stuff got out %b ack %b exp 1 0", tx_out, tx_ack);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_data_in = 1'b0; rx_in = 1'b0;
    tick(); tick();
    tx_point = 1'b1; sample_point = 1'b1;
    tick();
    tx_point = 1'b0; sample_point = 1'b0;
    checks++;
    if ({tx_out, tx_ack, rx_data_out, rx_valid} !== 4'b0101) begin
      errors++;
      $display("FAIL both_strobes got %b exp 0101", {tx_out, tx_ack, rx_data_out, rx_valid});
    end
  endtask

  initial begin
    test_reset();
    test_tx_stuff();
    test_rx_destuff();
    test_stuff_err();
    test_monitor();
    test_short_param();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
